// File: rtl/rv32_dma_engine.sv
// Word-granular memory-to-memory DMA initiator for the shared SRAM port.
// Copies one read beat then one write beat per word, and releases the bus for a cycle every BURST_LEN words.
module rv32_dma_engine #(
  parameter int XLEN      = 32,
  parameter int MEM_BYTES = 65536,
  parameter int BURST_LEN = 16,
  parameter int LEN_W     = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [XLEN-1:0]  src_addr,
  input  logic [XLEN-1:0]  dst_addr,
  input  logic [LEN_W-1:0] len_words,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] remaining,
  output logic             irq,
  input  logic             irq_clr,
  output logic             dma_req,
  output logic [XLEN-1:0]  dma_addr,
  output logic [XLEN-1:0]  dma_wdata,
  output logic             dma_we,
  input  logic [XLEN-1:0]  dma_rdata,
  input  logic             dma_grant
);

  localparam int BW = $clog2(BURST_LEN + 1);
  localparam logic [XLEN-1:0] WORD_STEP = XLEN'(4);
  localparam logic [XLEN:0]   MEM_LIM   = (XLEN+1)'(MEM_BYTES);

  typedef enum logic [2:0] {IDLE, RD, WR, YIELD, DONE} state_t;

  state_t          state;
  logic [XLEN-1:0] cur_src;
  logic [XLEN-1:0] cur_dst;
  logic [BW-1:0]   beat_cnt;
  logic [XLEN:0]   src_end;
  logic [XLEN:0]   dst_end;
  logic            bad_req;
  logic [LEN_W-1:0] rem_dec;

  // End-of-range sums are one bit wider than XLEN so an overflowing request cannot wrap into range.
  always_comb begin
    src_end = {1'b0, src_addr} + (XLEN+1)'({len_words, 2'b00});
    dst_end = {1'b0, dst_addr} + (XLEN+1)'({len_words, 2'b00});
    bad_req = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00) ||
              (src_end > MEM_LIM) || (dst_end > MEM_LIM);
  end

  assign rem_dec = remaining - LEN_W'(1);

  // Copy sequencer; every output is a register updated together with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_src   <= '0;
      cur_dst   <= '0;
      beat_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      remaining <= '0;
      irq       <= 1'b0;
      dma_req   <= 1'b0;
      dma_addr  <= '0;
      dma_wdata <= '0;
      dma_we    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (irq_clr) begin
        irq <= 1'b0;
      end
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            cur_src   <= src_addr;
            cur_dst   <= dst_addr;
            remaining <= len_words;
            beat_cnt  <= '0;
            busy      <= 1'b1;
            if (bad_req || (len_words == '0)) begin
              err   <= bad_req;
              state <= DONE;
              done  <= 1'b1;
              irq   <= 1'b1;
            end else begin
              err      <= 1'b0;
              state    <= RD;
              dma_req  <= 1'b1;
              dma_we   <= 1'b0;
              dma_addr <= src_addr;
            end
          end
        end
        RD: begin
          if (abort) begin
            err      <= 1'b1;
            state    <= DONE;
            done     <= 1'b1;
            irq      <= 1'b1;
            dma_req  <= 1'b0;
            dma_addr <= '0;
          end else if (dma_grant) begin
            cur_src   <= cur_src + WORD_STEP;
            dma_wdata <= dma_rdata;
            dma_we    <= 1'b1;
            dma_addr  <= cur_dst;
            state     <= WR;
          end else begin
            state <= RD;
          end
        end
        WR: begin
          if (dma_grant) begin
            cur_dst   <= cur_dst + WORD_STEP;
            remaining <= rem_dec;
            dma_wdata <= '0;
            dma_we    <= 1'b0;
            if (abort || (rem_dec == '0)) begin
              err      <= err | abort;
              state    <= DONE;
              done     <= 1'b1;
              irq      <= 1'b1;
              dma_req  <= 1'b0;
              dma_addr <= '0;
            end else if (beat_cnt + BW'(1) == BW'(BURST_LEN)) begin
              beat_cnt <= '0;
              state    <= YIELD;
              dma_req  <= 1'b0;
              dma_addr <= '0;
            end else begin
              beat_cnt <= beat_cnt + BW'(1);
              state    <= RD;
              dma_addr <= cur_src;
            end
          end else if (abort) begin
            err       <= 1'b1;
            state     <= DONE;
            done      <= 1'b1;
            irq       <= 1'b1;
            dma_req   <= 1'b0;
            dma_addr  <= '0;
            dma_wdata <= '0;
            dma_we    <= 1'b0;
          end else begin
            state <= WR;
          end
        end
        YIELD: begin
          if (abort) begin
            err   <= 1'b1;
            state <= DONE;
            done  <= 1'b1;
            irq   <= 1'b1;
          end else begin
            state    <= RD;
            dma_req  <= 1'b1;
            dma_addr <= cur_src;
          end
        end
        DONE: begin
          irq   <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          dma_req   <= 1'b0;
          dma_addr  <= '0;
          dma_wdata <= '0;
          dma_we    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/rv32_dma_engine.md
Name: rv32_dma_engine

Overview:
Accelerator-side DMA initiator that drives the SoC shared-memory DMA port (dma_req/dma_addr/dma_wdata/dma_we/dma_rdata/dma_grant).
- Performs word-granular memory-to-memory block copies inside the 64 KB unified SRAM.
- Each word is copied as one read beat followed by one write beat.
- Because dma_req stalls the RV32 core, the engine releases the bus for one cycle after every BURST_LEN words so the CPU can make progress.

Parameters:
XLEN, 32, data/address width
MEM_BYTES, 65536, size of the addressable SRAM window in bytes
BURST_LEN, 16, words copied before a mandatory one-cycle bus release (≥1)
LEN_W, 15, width of the word-count field

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin a copy; sampled only in IDLE
abort  input  1  terminate the active copy
src_addr  input  XLEN  source byte address; sampled with start
dst_addr  input  XLEN  destination byte address; sampled with start
len_words  input  LEN_W  number of words to copy; sampled with start
busy  output  1  high from the cycle after start is accepted until DONE completes
done  output  1  one-cycle pulse when a copy finishes or is rejected
err  output  1  status of the last copy (alignment, range or abort); holds until the next start
remaining  output  LEN_W  words not yet written
irq  output  1  level interrupt; set in DONE
irq_clr  input  1  clears irq
dma_req  output  1  bus request to the SoC DMA port
dma_addr  output  XLEN  byte address of the current beat
dma_wdata  output  XLEN  write data for the current beat
dma_we  output  1  1 = write beat, 0 = read beat
dma_rdata  input  XLEN  read data, valid in the same cycle as grant
dma_grant  input  1  beat accepted in this cycle

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs are 0, including remaining and all dma_* outputs. An in-flight copy is dropped with no further bus activity.
- States are IDLE, RD, WR, YIELD and DONE.
- IDLE: dma_req=0. On start:
  - Latch src, dst and len.
  - If src[1:0]!=0, dst[1:0]!=0, src+4*len>MEM_BYTES, or dst+4*len>MEM_BYTES (evaluate sums at XLEN+1 bits, no wrap): err=1, go to DONE.
  - Else if len==0: err=0, go to DONE.
  - Else: err=0, go to RD.
- RD: dma_req=1, dma_we=0, dma_addr=cur_src.
  - If dma_grant: capture dma_rdata into the data buffer, cur_src+=4, go to WR.
  - If no grant: hold all dma_* outputs stable and stay in RD.
- WR: dma_req=1, dma_we=1, dma_addr=cur_dst, dma_wdata=buffer.
  - If dma_grant: cur_dst+=4, remaining-=1, beat_cnt+=1.
  - Then: if remaining becomes 0, go to DONE. Else if beat_cnt reaches BURST_LEN, reset beat_cnt and go to YIELD. Else go to RD.
  - If no grant: hold outputs stable.
- YIELD: dma_req=0 for exactly one cycle, then go to RD.
- DONE: dma_req=0, done=1 for one cycle, irq set to 1, then go to IDLE.
- busy: 1 in RD, WR, YIELD and DONE; 0 in IDLE.
- irq: set has priority over a simultaneous irq_clr; otherwise irq_clr clears it.
- dma_addr, dma_wdata and dma_we are 0 whenever dma_req=0.
- abort in RD, WR or YIELD:
  - If a write beat is granted in the same cycle, that write completes.
  - A word already read but not yet written is discarded.
  - Go to DONE with err=1; remaining keeps the unwritten count.
  - abort is ignored in IDLE and DONE.
- start outside IDLE is ignored and changes no latched value.
- Overlapping ranges: always an ascending forward copy; with dst>src the result is defined by that order, not memmove semantics.
- Timing with grant always high:
  - start sampled in cycle 0; first RD in cycle 1.
  - done in cycle 2N+Y+1, where Y=floor((N-1)/BURST_LEN).
  - Each withheld-grant cycle adds 1.

Test Plan:
1. SRAM preloaded with 0x11,0x22,0x33,0x44 at 0x100..0x10C, grant=req; start src=0x100 dst=0x200 len=4 -> done in cycle 9, err=0, 0x200..0x20C match the source, irq=1, remaining=0.
2. len=20, BURST_LEN=16 -> exactly one dma_req=0 cycle after the 16th write (cycle 33); done in cycle 42; all 20 words copied.
3. Rejection cases, each with done in cycle 1, dma_req never high, and dst memory unchanged:
   - src=0x102 -> err=1.
   - dst=0xFFF8, len=4 -> err=1.
   - len=0 -> err=0.
4. Grant withheld for 3 cycles during the first RD of len=1 -> dma_addr=src and dma_we=0 stable throughout; done in cycle 6; data correct.
5. abort asserted in the WR cycle of word 3 of 8 with grant high -> words 1..3 written, word 4 never written, err=1, remaining=5, done the next cycle.
6. rst_n pulled low during WR of len=8 -> dma_req, busy and irq drop immediately; after release state=IDLE; a following start runs normally. irq_clr in the same cycle as done -> irq=1.
